imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/cotm32_pkg.sv | 27 ++
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cotm32_pkg.sv
// cotm32_pkg: core-wide widths shared by the cotm32 blocks, plus the
// instruction-memory loader state type and its checksum helper.
package cotm32_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;

  // Loader session states
  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN  = 3'd1,
    LDR_DATA = 3'd2,
    LDR_CSUM = 3'd3,
    LDR_DONE = 3'd4,
    LDR_ERR  = 3'd5
  } ldr_state_e;

  // Running stream checksum: XOR of every payload byte
  function automatic logic [BYTE_WIDTH-1:0] csum_next(
    input logic [BYTE_WIDTH-1:0] acc,
    input logic [BYTE_WIDTH-1:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (4-byte little-endian word count N,
// 4*N payload bytes, 1 XOR checksum byte) and writes the payload words into
// instruction memory through its synchronous write port. The core is stalled
// while o_busy is high.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             one-cycle request to begin a session (IDLE/DONE/ERR only)
//   i_byte_valid/i_byte stream byte, accepted when o_byte_ready is also high
//   o_byte_ready        high in LEN, DATA, CSUM
//   o_wr_en/addr/data   one-cycle memory write strobe per assembled word
//   o_busy              session in progress
//   o_done/o_err        sticky session result, cleared by i_start
module imem_loader
  import cotm32_pkg::*;
#(
  parameter int              MEM_SIZE  = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_byte_ready,
  output logic                  o_wr_en,
  output logic [XLEN-1:0]       o_wr_addr,
  output logic [INST_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  // One extra bit so that N == MEM_SIZE is representable
  localparam int CNT_W = $clog2(MEM_SIZE) + 1;

  ldr_state_e            r_state;
  ldr_state_e            w_next_state;
  logic [1:0]            r_byte_idx;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [XLEN-1:0]       r_len;
  logic [BYTE_WIDTH-1:0] r_csum;
  logic [INST_WIDTH-1:0] r_word;
  logic                  r_wr_en;
  logic [XLEN-1:0]       r_wr_addr;
  logic [INST_WIDTH-1:0] r_wr_data;
  logic                  r_done;
  logic                  r_err;

  logic                  w_byte_ready;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_len_too_big;
  logic [XLEN-1:0]       w_len_full;
  logic [INST_WIDTH-1:0] w_word_full;
  logic [XLEN-1:0]       w_wr_addr;

  assign w_accept      = i_byte_valid & w_byte_ready;
  assign w_last_byte   = (r_byte_idx == 2'd3);
  assign w_last_word   = ((XLEN'(r_word_cnt) + XLEN'(32'd1)) == r_len);
  assign w_len_too_big = (w_len_full > XLEN'(MEM_SIZE));
  assign w_wr_addr     = BASE_ADDR + XLEN'({r_word_cnt, 2'b00});

  // Merge the incoming byte into its little-endian slot of the length/word
  always_comb begin
    w_len_full  = r_len;
    w_word_full = r_word;
    w_len_full[{r_byte_idx, 3'b000} +: BYTE_WIDTH]  = i_byte;
    w_word_full[{r_byte_idx, 3'b000} +: BYTE_WIDTH] = i_byte;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LDR_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (i_start) w_next_state = LDR_LEN;
        else         w_next_state = r_state;
      end
      LDR_LEN: begin
        if (w_accept && w_last_byte) begin
          if (w_len_too_big)                      w_next_state = LDR_ERR;
          else if (w_len_full == {XLEN{1'b0}})    w_next_state = LDR_CSUM;
          else                                    w_next_state = LDR_DATA;
        end else begin
          w_next_state = LDR_LEN;
        end
      end
      LDR_DATA: begin
        if (w_accept && w_last_byte && w_last_word) w_next_state = LDR_CSUM;
        else                                        w_next_state = LDR_DATA;
      end
      LDR_CSUM: begin
        if (w_accept) begin
          if (i_byte == r_csum) w_next_state = LDR_DONE;
          else                  w_next_state = LDR_ERR;
        end else begin
          w_next_state = LDR_CSUM;
        end
      end
      default: w_next_state = LDR_IDLE;
    endcase
  end

  // FSM outputs: handshake and stall are pure functions of the state
  always_comb begin
    w_byte_ready = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      LDR_LEN, LDR_DATA, LDR_CSUM: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
      end
      default: begin
        w_byte_ready = 1'b0;
        w_busy       = 1'b0;
      end
    endcase
  end

  // Datapath: length/word assembly, checksum, write strobe and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_idx <= 2'd0;
      r_word_cnt <= {CNT_W{1'b0}};
      r_len      <= {XLEN{1'b0}};
      r_csum     <= {BYTE_WIDTH{1'b0}};
      r_word     <= {INST_WIDTH{1'b0}};
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= {INST_WIDTH{1'b0}};
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        LDR_IDLE, LDR_DONE, LDR_ERR: begin
          if (i_start) begin
            r_byte_idx <= 2'd0;
            r_word_cnt <= {CNT_W{1'b0}};
            r_len      <= {XLEN{1'b0}};
            r_csum     <= {BYTE_WIDTH{1'b0}};
            r_word     <= {INST_WIDTH{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        LDR_LEN: begin
          if (w_accept) begin
            r_len      <= w_len_full;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte && w_len_too_big) r_err <= 1'b1;
          end
        end
        LDR_DATA: begin
          if (w_accept) begin
            r_word     <= w_word_full;
            r_csum     <= csum_next(r_csum, i_byte);
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              // Strobe is registered, so it appears the cycle after the 4th byte
              r_wr_en    <= 1'b1;
              r_wr_addr  <= w_wr_addr;
              r_wr_data  <= w_word_full;
              r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        LDR_CSUM: begin
          if (w_accept) begin
            if (i_byte == r_csum) r_done <= 1'b1;
            else                  r_err  <= 1'b1;
          end
        end
        default: begin
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = w_byte_ready;
  assign o_busy       = w_busy;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
